// File: rtl/ps2_line_buffer.sv
// Collects edge-detected PS/2 ASCII keystrokes into an editable live line and commits it on the terminator key.
// Latency 1 cycle from key event to outputs; no backpressure, and printable keys arriving on a full line are dropped and flagged.
module ps2_line_buffer #(
    parameter int                MAX_CHARS = 32,
    parameter int                CHAR_W    = 8,
    parameter logic [CHAR_W-1:0] TERM_CHAR = CHAR_W'(8'h0a),
    parameter logic [CHAR_W-1:0] BS_CHAR   = CHAR_W'(8'h08),
    parameter int                LEN_W     = 6
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [CHAR_W-1:0]             ascii_char,
    input  logic                          key_pressed,
    output logic [MAX_CHARS*CHAR_W-1:0]   live_content,
    output logic [LEN_W-1:0]              live_length,
    output logic [MAX_CHARS*CHAR_W-1:0]   line_content,
    output logic [LEN_W-1:0]              line_length,
    output logic                          line_ready,
    output logic                          overflow
);

    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_CHARS);
    localparam logic [LEN_W-1:0] ONE     = LEN_W'(1);

    logic                        key_q, key_d;
    logic [LEN_W-1:0]            live_len_q, live_len_d;
    logic [MAX_CHARS*CHAR_W-1:0] line_q, line_d;
    logic [LEN_W-1:0]            line_len_q, line_len_d;
    logic                        line_ready_q, line_ready_d;
    logic                        overflow_q, overflow_d;

    logic key_evt, is_term, is_bs, is_print;
    logic term_evt, bs_evt, wr_evt, ovf_evt;

    // A key event is the rising edge of the decoder strobe, so a held key counts once.
    assign key_evt  = key_pressed & ~key_q;
    assign is_term  = (ascii_char == TERM_CHAR);
    assign is_bs    = (ascii_char == BS_CHAR);
    assign is_print = ~is_term & ~is_bs;

    assign term_evt = key_evt & is_term;
    assign bs_evt   = key_evt & is_bs & (live_len_q != '0);
    assign wr_evt   = key_evt & is_print & (live_len_q != MAX_LEN);
    assign ovf_evt  = key_evt & is_print & (live_len_q == MAX_LEN);

    always_comb begin
        key_d        = key_pressed;
        live_len_d   = live_len_q;
        line_d       = line_q;
        line_len_d   = line_len_q;
        line_ready_d = 1'b0;
        overflow_d   = overflow_q;
        if (term_evt) begin
            line_d       = live_content;
            line_len_d   = live_len_q;
            line_ready_d = 1'b1;
            live_len_d   = '0;
            overflow_d   = 1'b0;
        end else if (bs_evt) begin
            live_len_d = live_len_q - ONE;
        end else if (wr_evt) begin
            live_len_d = live_len_q + ONE;
        end else if (ovf_evt) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            key_q        <= 1'b0;
            live_len_q   <= '0;
            line_q       <= '0;
            line_len_q   <= '0;
            line_ready_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            key_q        <= key_d;
            live_len_q   <= live_len_d;
            line_q       <= line_d;
            line_len_q   <= line_len_d;
            line_ready_q <= line_ready_d;
            overflow_q   <= overflow_d;
        end
    end

    // Each slot decodes its own write enable from the current length; slot 0 sits in the MSBs.
    for (genvar gi = 0; gi < MAX_CHARS; gi++) begin : g_slot
        logic [CHAR_W-1:0] slot_q, slot_d;

        always_comb begin
            slot_d = slot_q;
            if (term_evt) begin
                slot_d = '0;
            end else if (wr_evt && (live_len_q == LEN_W'(gi))) begin
                slot_d = ascii_char;
            end else if (bs_evt && (live_len_q == LEN_W'(gi + 1))) begin
                slot_d = '0;
            end
        end

        always_ff @(posedge clock) begin
            if (reset) begin
                slot_q <= '0;
            end else begin
                slot_q <= slot_d;
            end
        end

        assign live_content[(MAX_CHARS-gi)*CHAR_W-1 -: CHAR_W] = slot_q;
    end

    assign live_length  = live_len_q;
    assign line_content = line_q;
    assign line_length  = line_len_q;
    assign line_ready   = line_ready_q;
    assign overflow     = overflow_q;

endmodule

// File: tb/tb_ps2_line_buffer.sv
// Table-driven keystroke vectors plus hand-written corner sequences; committed lines are checked through a scoreboard queue.
module tb_ps2_line_buffer;

    logic         clock = 1'b0;
    logic         reset;
    logic [7:0]   ascii_char;
    logic         key_pressed;
    logic [255:0] live_content;
    logic [5:0]   live_length;
    logic [255:0] line_content;
    logic [5:0]   line_length;
    logic         line_ready;
    logic         overflow;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [255:0] content;
        logic [5:0]   len;
    } commit_t;

    commit_t sb_q[$];

    typedef struct {
        logic [7:0]   ch;
        int           hold;
        int           gap;
        logic [5:0]   len;
        logic [15:0]  top;
        logic         ovf;
        logic         commit;
        logic [255:0] line;
        logic [5:0]   line_len;
    } vec_t;

    vec_t tbl[15];

    ps2_line_buffer dut (
        .clock        (clock),
        .reset        (reset),
        .ascii_char   (ascii_char),
        .key_pressed  (key_pressed),
        .live_content (live_content),
        .live_length  (live_length),
        .line_content (line_content),
        .line_length  (line_length),
        .line_ready   (line_ready),
        .overflow     (overflow)
    );

    always #5 clock = ~clock;

    function automatic logic [255:0] top16(input logic [15:0] t);
        return {t, 240'b0};
    endfunction

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic strobe(input logic [7:0] ch, input int hold, input int gap);
        ascii_char  = ch;
        key_pressed = 1'b1;
        repeat (hold) tick();
        key_pressed = 1'b0;
        repeat (gap) tick();
    endtask

    // Every line_ready pulse must match the oldest expected commit.
    always @(negedge clock) begin
        if (reset === 1'b0 && line_ready === 1'b1) begin
            total++;
            if (sb_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_ready got=1 want=0 len=%0d", line_length);
            end else begin
                commit_t e;
                e = sb_q.pop_front();
                chk("commit_content", line_content, e.content);
                chk("commit_length", 256'(line_length), 256'(e.len));
            end
        end
    end

    initial begin
        logic [255:0] full_line;

        tbl[0]  = '{8'h34, 3, 2, 6'd1, 16'h3400, 1'b0, 1'b0, 256'b0, 6'd0};
        tbl[1]  = '{8'h35, 3, 2, 6'd2, 16'h3435, 1'b0, 1'b0, 256'b0, 6'd0};
        tbl[2]  = '{8'h0a, 3, 2, 6'd0, 16'h0000, 1'b0, 1'b1, top16(16'h3435), 6'd2};
        tbl[3]  = '{8'h41, 3, 2, 6'd1, 16'h4100, 1'b0, 1'b0, 256'b0, 6'd0};
        tbl[4]  = '{8'h42, 3, 2, 6'd2, 16'h4142, 1'b0, 1'b0, 256'b0, 6'd0};
        tbl[5]  = '{8'h08, 3, 2, 6'd1, 16'h4100, 1'b0, 1'b0, 256'b0, 6'd0};
        tbl[6]  = '{8'h43, 3, 2, 6'd2, 16'h4143, 1'b0, 1'b0, 256'b0, 6'd0};
        tbl[7]  = '{8'h0a, 3, 2, 6'd0, 16'h0000, 1'b0, 1'b1, top16(16'h4143), 6'd2};
        tbl[8]  = '{8'h0a, 3, 2, 6'd0, 16'h0000, 1'b0, 1'b1, 256'b0, 6'd0};
        tbl[9]  = '{8'h5a, 20, 2, 6'd1, 16'h5a00, 1'b0, 1'b0, 256'b0, 6'd0};
        tbl[10] = '{8'h08, 3, 2, 6'd0, 16'h0000, 1'b0, 1'b0, 256'b0, 6'd0};
        tbl[11] = '{8'h08, 3, 2, 6'd0, 16'h0000, 1'b0, 1'b0, 256'b0, 6'd0};
        tbl[12] = '{8'h58, 1, 1, 6'd1, 16'h5800, 1'b0, 1'b0, 256'b0, 6'd0};
        tbl[13] = '{8'h0a, 1, 1, 6'd0, 16'h0000, 1'b0, 1'b1, top16(16'h5800), 6'd1};
        tbl[14] = '{8'h59, 1, 1, 6'd1, 16'h5900, 1'b0, 1'b0, 256'b0, 6'd0};

        reset       = 1'b1;
        ascii_char  = 8'h00;
        key_pressed = 1'b0;
        repeat (2) tick();
        chk("rst_live", live_content, 256'b0);
        chk("rst_live_len", 256'(live_length), 256'd0);
        chk("rst_line", line_content, 256'b0);
        chk("rst_ready", 256'(line_ready), 256'd0);
        chk("rst_ovf", 256'(overflow), 256'd0);
        reset = 1'b0;
        tick();

        for (int i = 0; i < 15; i++) begin
            if (tbl[i].commit) sb_q.push_back('{tbl[i].line, tbl[i].line_len});
            strobe(tbl[i].ch, tbl[i].hold, tbl[i].gap);
            chk($sformatf("vec%0d_len", i), 256'(live_length), 256'(tbl[i].len));
            chk($sformatf("vec%0d_live", i), live_content, top16(tbl[i].top));
            chk($sformatf("vec%0d_ovf", i), 256'(overflow), 256'(tbl[i].ovf));
        end

        // Committed 'X' stays put while 'Y' is being typed.
        chk("held_line", line_content, top16(16'h5800));
        chk("held_line_len", 256'(line_length), 256'd1);

        // Reset mid-entry with a terminator on the bus must not commit.
        ascii_char  = 8'h0a;
        key_pressed = 1'b1;
        reset       = 1'b1;
        tick();
        chk("mid_rst_live", live_content, 256'b0);
        chk("mid_rst_live_len", 256'(live_length), 256'd0);
        chk("mid_rst_line", line_content, 256'b0);
        chk("mid_rst_line_len", 256'(line_length), 256'd0);
        chk("mid_rst_ready", 256'(line_ready), 256'd0);
        chk("mid_rst_ovf", 256'(overflow), 256'd0);
        key_pressed = 1'b0;
        reset       = 1'b0;
        repeat (3) tick();
        chk("post_rst_ready", 256'(line_ready), 256'd0);

        full_line = '0;
        for (int i = 0; i < 34; i++) begin
            logic [7:0] c;
            c = 8'h61 + 8'(i);
            if (i < 32) full_line[(32-i)*8-1 -: 8] = c;
            strobe(c, 2, 2);
            chk($sformatf("fill%0d_len", i), 256'(live_length), 256'((i < 32) ? i + 1 : 32));
            chk($sformatf("fill%0d_ovf", i), 256'(overflow), 256'((i >= 32) ? 1 : 0));
        end
        chk("slot31", 256'(live_content[7:0]), 256'(8'h80));
        chk("full_live", live_content, full_line);
        sb_q.push_back('{full_line, 6'd32});
        strobe(8'h0a, 3, 2);
        chk("ovf_cleared", 256'(overflow), 256'd0);
        chk("full_live_len", 256'(live_length), 256'd0);

        repeat (3) tick();
        chk("sb_drained", 256'(sb_q.size()), 256'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ps2_line_buffer.md
Name: ps2_line_buffer

Overview:
- Parametrised successor to the single-line PS/2 keystroke collector.
- Assembles ASCII keystrokes into an editable live line, with backspace and overflow handling.
- On the terminator key, commits the line to a stable output register and pulses a one-cycle ready strobe.
- Sits between the PS/2 ASCII decoder and the command interpreter (velocity/angle parser). Fully synchronous to one clock; key strobes are edge-detected, never used as clocks.

Parameters:
MAX_CHARS, 32, line capacity in characters (>=2)
CHAR_W, 8, bits per character
TERM_CHAR, 8'h0a, line terminator code
BS_CHAR, 8'h08, backspace code
LEN_W, 6, width of length outputs; must satisfy 2^LEN_W > MAX_CHARS

Ports:
clock  in  1  system clock
reset  in  1  synchronous active-high reset
ascii_char  in  CHAR_W  decoded key code, valid while key_pressed high
key_pressed  in  1  key strobe from decoder; level, may stay high multiple cycles
live_content  out  MAX_CHARS*CHAR_W  line being typed; char 0 in MSBs, unused slots zero
live_length  out  LEN_W  characters currently in live line
line_content  out  MAX_CHARS*CHAR_W  last committed line, same packing, held until next commit
line_length  out  LEN_W  length of committed line
line_ready  out  1  one-cycle pulse, the cycle line_content/line_length update
overflow  out  1  sticky: a printable char was dropped because the live line was full

Behaviour:
- Reset (synchronous, active-high; wins over everything): all outputs and the internal key_pressed delay register go to 0.
- Key event: key_pressed high this cycle and low the previous cycle (registered edge detect). Exactly one event per strobe, regardless of hold length. ascii_char is sampled in the event cycle.
- Latency: outputs reflect an event on the clock edge that ends the event cycle (1 cycle).
- Slot packing: slot i occupies bits [(MAX_CHARS-i)*CHAR_W-1 -: CHAR_W].
- Event = TERM_CHAR:
  - line_content <= live_content; line_length <= live_length; line_ready <= 1 for that single cycle.
  - live_content <= 0; live_length <= 0; overflow <= 0.
  - An empty line still commits (line_length = 0, line_ready pulses).
- Event = BS_CHAR:
  - If live_length > 0: live_length decrements; slot live_length-1 is cleared to 0.
  - If live_length = 0: no change.
  - Never affects overflow.
- Any other code (printable):
  - If live_length < MAX_CHARS: slot live_length <= ascii_char; live_length increments.
  - If live_length = MAX_CHARS: char dropped, contents unchanged, overflow <= 1.
- line_ready is 0 in every cycle without a terminator event.
- line_content and line_length change only on terminator events or reset.
- Reset mid-line discards the live line and the committed line.
- The bench guarantees key_pressed low for at least one cycle between strobes. Back-to-back events two cycles apart must all be processed.
- No state machine beyond the edge detector, the length counter and the sticky flag. Implement slot writes as a decoded write-enable per slot (generate loop), not a chained if/else.

Test Plan:
- Reset, then strobe '4','5',0x0a (each 3 cycles high, 2 low) -> one-cycle line_ready; line_content top 16 bits = 16'h3435, rest 0; line_length=2; live_length=0.
- Strobe 'A','B',0x08,'C',0x0a -> committed top 16 bits = 16'h4143, line_length=2; after the backspace, live slot 1 reads 0 and live_length=1.
- Strobe 34 printable chars 'a'.. with MAX_CHARS=32 -> live_length stops at 32; overflow rises on char 33 and stays high; slot 31 = 'a'+31. Then 0x0a -> line_length=32, overflow clears.
- key_pressed held high 20 cycles with 'Z' -> exactly one char stored (live_length=1); 0x08 on empty line -> live_length stays 0.
- Type 'X', 0x0a, then 'Y' -> line_content still holds 'X' (line_length=1) while live shows 'Y'. Assert reset mid-entry -> all outputs 0 the next cycle, and no line_ready pulse.
- 0x0a on an empty line -> line_ready pulses, line_length=0, line_content=0.
